decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: splits an instruction into fields and gathers both operands
// from the register file, the immediate, or memory, then presents them on a valid/ready port.
module decode_stage #(
    parameter int OPC_W  = 6,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 12,
    parameter int DATA_W = 16,
    localparam int INSTR_W = OPC_W + 2 + REG_AW + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               rf_rd_en,
    output logic [REG_AW-1:0]  rf_rd_id1,
    output logic [REG_AW-1:0]  rf_rd_id2,
    input  logic [DATA_W-1:0]  rf_data1,
    input  logic [DATA_W-1:0]  rf_data2,
    output logic               mem_req,
    output logic [DATA_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [1:0]         out_mode,
    output logic [DATA_W-1:0]  out_op1,
    output logic [DATA_W-1:0]  out_op2,
    output logic [REG_AW-1:0]  out_wb_reg,
    output logic               out_illegal
);

    typedef enum logic [1:0] {IDLE, REG_RD, MEM_RD, OUT} state_t;

    state_t             state;
    logic [IMM_W-1:0]   imm_q;
    logic [OPC_W-1:0]   in_opc;
    logic [1:0]         in_mode;
    logic [REG_AW-1:0]  in_rd;
    logic [IMM_W-1:0]   in_imm;
    logic [REG_AW-1:0]  in_rs;

    assign in_opc  = in_instr[INSTR_W-1 -: OPC_W];
    assign in_mode = in_instr[IMM_W+REG_AW +: 2];
    assign in_rd   = in_instr[IMM_W +: REG_AW];
    assign in_imm  = in_instr[IMM_W-1:0];
    assign in_rs   = in_imm[IMM_W-1 -: REG_AW];

    // The register read is issued in the accept cycle so its data lands during REG_RD.
    assign in_ready  = (state == IDLE) && !rst;
    assign rf_rd_en  = in_valid && in_ready;
    assign rf_rd_id1 = rf_rd_en ? in_rd : '0;
    assign rf_rd_id2 = rf_rd_en ? in_rs : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            imm_q       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_mode    <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_wb_reg  <= '0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_opcode <= in_opc;
                        out_mode   <= in_mode;
                        out_wb_reg <= in_rd;
                        imm_q      <= in_imm;
                        state      <= REG_RD;
                    end
                end
                REG_RD: begin
                    out_op1     <= rf_data1;
                    out_illegal <= 1'b0;
                    case (out_mode)
                        2'b00: begin
                            out_op2   <= rf_data2;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                        2'b10: begin
                            out_op2   <= DATA_W'(imm_q);
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                        2'b11: begin
                            out_op2     <= '0;
                            out_illegal <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= OUT;
                        end
                        default: begin
                            mem_req  <= 1'b1;
                            mem_addr <= DATA_W'(imm_q);
                            state    <= MEM_RD;
                        end
                    endcase
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        out_op2   <= mem_data;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a small register-file model plus hand-driven
// memory acknowledges, checked against hand-computed operand values.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_id1;
    logic [3:0]  rf_rd_id2;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [1:0]  out_mode;
    logic [15:0] out_op1;
    logic [15:0] out_op2;
    logic [3:0]  out_wb_reg;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;
    logic [15:0] rf [16];

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_rd_en(rf_rd_en), .rf_rd_id1(rf_rd_id1), .rf_rd_id2(rf_rd_id2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_mode(out_mode), .out_op1(out_op1), .out_op2(out_op2),
        .out_wb_reg(out_wb_reg), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: data is valid only in the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        rf_data1 <= rf_rd_en ? rf[rf_rd_id1] : 16'hDEAD;
        rf_data2 <= rf_rd_en ? rf[rf_rd_id2] : 16'hDEAD;
    end

    function automatic logic [23:0] mk(input logic [5:0] opc, input logic [1:0] mode,
                                       input logic [3:0] rd, input logic [11:0] imm);
        return {opc, mode, rd, imm};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(6'h01, 2'b00, 4'h2, 12'h300);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (rf_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_rd_en: got %b expected 0", rf_rd_en); end
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0)
            begin errors++; $display("[TB] FAIL reset_ctrl: got valid=%b req=%b addr=%h expected 0/0/0000", out_valid, mem_req, mem_addr); end
        checks++; if ({out_opcode, out_mode, out_op1, out_op2, out_wb_reg, out_illegal} !== 45'h0)
            begin errors++; $display("[TB] FAIL reset_outputs: got opc=%h mode=%b op1=%h op2=%h wb=%h ill=%b expected all 0",
                                     out_opcode, out_mode, out_op1, out_op2, out_wb_reg, out_illegal); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_mode00();
        @(negedge clk);
        in_instr = mk(6'h01, 2'b00, 4'h2, 12'h300);
        in_valid = 1'b1;
        #1;
        checks++; if (rf_rd_en !== 1'b1 || rf_rd_id1 !== 4'h2 || rf_rd_id2 !== 4'h3)
            begin errors++; $display("[TB] FAIL m00_rf_read: got en=%b id1=%h id2=%h expected 1/2/3", rf_rd_en, rf_rd_id1, rf_rd_id2); end
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 24'hFFFFFF;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_rd_en !== 1'b0)
            begin errors++; $display("[TB] FAIL m00_cycle1: got valid=%b ready=%b en=%b expected 0/0/0", out_valid, in_ready, rf_rd_en); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL m00_latency: got out_valid=%b expected 1 at cycle 2", out_valid); end
        checks++; if (out_op1 !== 16'h1111 || out_op2 !== 16'h2222)
            begin errors++; $display("[TB] FAIL m00_operands: got %h/%h expected 1111/2222", out_op1, out_op2); end
        checks++; if (out_opcode !== 6'h01 || out_mode !== 2'b00 || out_wb_reg !== 4'h2 || out_illegal !== 1'b0)
            begin errors++; $display("[TB] FAIL m00_fields: got opc=%h mode=%b wb=%h ill=%b expected 01/00/2/0", out_opcode, out_mode, out_wb_reg, out_illegal); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL m00_handshake: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_mode10();
        int reqs;
        reqs = 0;
        @(negedge clk);
        in_instr = mk(6'h2A, 2'b10, 4'h5, 12'hABC);
        in_valid = 1'b1;
        #1;
        if (mem_req) reqs++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (mem_req) reqs++;
        @(negedge clk);
        #1;
        if (mem_req) reqs++;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 16'h1005 || out_op2 !== 16'h0ABC)
            begin errors++; $display("[TB] FAIL m10_operands: got valid=%b op1=%h op2=%h expected 1/1005/0ABC", out_valid, out_op1, out_op2); end
        checks++; if (out_illegal !== 1'b0 || out_opcode !== 6'h2A || out_mode !== 2'b10)
            begin errors++; $display("[TB] FAIL m10_fields: got ill=%b opc=%h mode=%b expected 0/2A/10", out_illegal, out_opcode, out_mode); end
        checks++; if (reqs !== 0) begin errors++; $display("[TB] FAIL m10_no_mem: got %0d mem_req cycles expected 0", reqs); end
        @(negedge clk);
    endtask

    task automatic test_mode11();
        int reqs;
        reqs = 0;
        @(negedge clk);
        in_instr = mk(6'h3F, 2'b11, 4'hF, 12'h123);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (mem_req) reqs++;
        @(negedge clk);
        #1;
        if (mem_req) reqs++;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 16'h100F || out_op2 !== 16'h0000 || out_illegal !== 1'b1)
            begin errors++; $display("[TB] FAIL m11_illegal: got valid=%b op1=%h op2=%h ill=%b expected 1/100F/0000/1", out_valid, out_op1, out_op2, out_illegal); end
        checks++; if (reqs !== 0) begin errors++; $display("[TB] FAIL m11_no_mem: got %0d mem_req cycles expected 0", reqs); end
        @(negedge clk);
    endtask

    task automatic test_mode01();
        int bad;
        bad = 0;
        @(negedge clk);
        in_instr = mk(6'h05, 2'b01, 4'h7, 12'h040);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // A stray acknowledge during REG_RD must not be taken as the memory response.
        mem_ack = 1'b1;
        mem_data = 16'h5555;
        #1;
        checks++; if (mem_req !== 1'b0 || rf_rd_en !== 1'b0)
            begin errors++; $display("[TB] FAIL m01_cycle1: got req=%b en=%b expected 0/0", mem_req, rf_rd_en); end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040)
            begin errors++; $display("[TB] FAIL m01_request: got req=%b addr=%h expected 1/0040", mem_req, mem_addr); end
        for (int k = 2; k <= 6; k++) begin
            if (k > 2) begin
                @(negedge clk);
                #1;
            end
            if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || out_valid !== 1'b0 || rf_rd_en !== 1'b0) bad++;
            if (k == 6) begin
                mem_ack = 1'b1;
                mem_data = 16'hBEEF;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL m01_wait_stable: got %0d bad wait cycles expected 0", bad); end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        #1;
        checks++; if (out_valid !== 1'b1 || out_op2 !== 16'hBEEF || out_op1 !== 16'h1007)
            begin errors++; $display("[TB] FAIL m01_result: got valid=%b op1=%h op2=%h expected 1/1007/BEEF at cycle 7", out_valid, out_op1, out_op2); end
        checks++; if (mem_req !== 1'b0 || out_mode !== 2'b01 || out_wb_reg !== 4'h7 || out_illegal !== 1'b0)
            begin errors++; $display("[TB] FAIL m01_fields: got req=%b mode=%b wb=%h ill=%b expected 0/01/7/0", mem_req, out_mode, out_wb_reg, out_illegal); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        @(negedge clk);
        in_instr = mk(6'h03, 2'b00, 4'h3, 12'h200);
        in_valid = 1'b1;
        @(negedge clk);
        in_instr = mk(6'h09, 2'b10, 4'h1, 12'h00F);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 16'h2222 || out_op2 !== 16'h1111 || out_opcode !== 6'h03)
            begin errors++; $display("[TB] FAIL stall_entry: got valid=%b op1=%h op2=%h opc=%h expected 1/2222/1111/03", out_valid, out_op1, out_op2, out_opcode); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_instr = mk(6'(k), 2'b11, 4'(k), 12'hFFF);
            #1;
            if (out_valid !== 1'b1 || out_op1 !== 16'h2222 || out_op2 !== 16'h1111 || out_opcode !== 6'h03 ||
                out_mode !== 2'b00 || out_wb_reg !== 4'h3 || in_ready !== 1'b0 || rf_rd_en !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_frozen: got %0d changed cycles expected 0", bad); end
        in_instr = mk(6'h09, 2'b10, 4'h1, 12'h00F);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rf_rd_en !== 1'b1 || rf_rd_id1 !== 4'h1)
            begin errors++; $display("[TB] FAIL b2b_accept: got valid=%b ready=%b en=%b id1=%h expected 0/1/1/1", out_valid, in_ready, rf_rd_en, rf_rd_id1); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 16'h1001 || out_op2 !== 16'h000F || out_opcode !== 6'h09)
            begin errors++; $display("[TB] FAIL b2b_second: got valid=%b op1=%h op2=%h opc=%h expected 1/1001/000F/09", out_valid, out_op1, out_op2, out_opcode); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk);
        in_instr = mk(6'h04, 2'b01, 4'h6, 12'h080);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0080)
            begin errors++; $display("[TB] FAIL rmid_request: got req=%b addr=%h expected 1/0080", mem_req, mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || in_ready !== 1'b0 || out_op1 !== 16'h0 || out_opcode !== 6'h0 || out_wb_reg !== 4'h0)
            begin errors++; $display("[TB] FAIL rmid_reset_values: got req=%b addr=%h ready=%b op1=%h opc=%h wb=%h expected 0/0000/0/0000/00/0",
                                     mem_req, mem_addr, in_ready, out_op1, out_opcode, out_wb_reg); end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_data = 16'h7777;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle: got in_ready=%b expected 1", in_ready); end
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        #1;
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || out_op2 !== 16'h0 || in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL rmid_late_ack: got valid=%b req=%b op2=%h ready=%b expected 0/0/0000/1", out_valid, mem_req, out_op2, in_ready); end
        in_instr = mk(6'h02, 2'b00, 4'h8, 12'h900);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 16'h1008 || out_op2 !== 16'h1009 || out_wb_reg !== 4'h8 || out_opcode !== 6'h02)
            begin errors++; $display("[TB] FAIL rmid_next_instr: got valid=%b op1=%h op2=%h wb=%h opc=%h expected 1/1008/1009/8/02",
                                     out_valid, out_op1, out_op2, out_wb_reg, out_opcode); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        rf[2] = 16'h1111;
        rf[3] = 16'h2222;
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        mem_ack = 1'b0;
        mem_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_mode00();
        test_mode10();
        test_mode11();
        test_mode01();
        test_back_to_back();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
